// File: rtl/image_stream_sched_if.sv
// Request/grant/completion bundle between the image sources, the image glue and the
// round-robin scheduler.
interface image_stream_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_grant;
  logic [ID_W-1:0]    o_grant_id;
  logic               o_img_cmd_pulse;
  logic               i_image_done_pulse;
  logic [NUM_REQ-1:0] o_req_done;
  logic [NUM_REQ-1:0] o_req_err;
  logic               o_busy;
  logic               o_timeout_err;
  logic               i_err_clr;
  logic [CNT_W-1:0]   o_xfer_count;

  // Scheduler side
  modport slave (
    input  i_req, i_image_done_pulse, i_err_clr,
    output o_grant, o_grant_id, o_img_cmd_pulse, o_req_done, o_req_err, o_busy,
           o_timeout_err, o_xfer_count
  );

  // Requester / glue side
  modport master (
    output i_req, i_image_done_pulse, i_err_clr,
    input  o_grant, o_grant_id, o_img_cmd_pulse, o_req_done, o_req_err, o_busy,
           o_timeout_err, o_xfer_count
  );
endinterface

// File: rtl/image_stream_sched.sv
// Round-robin scheduler granting the shared image-streaming path to one source at a time,
// holding the grant until image completion or watchdog expiry.
module image_stream_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input logic                 i_clk,
  input logic                 i_rst,
  image_stream_sched_if.slave bus
);

  localparam int unsigned        WdW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0]     WdMax   = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  typedef enum logic [2:0] {StIdle, StGrant, StIssue, StWait, StRelease} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               cmd_q, cmd_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [WdW-1:0]     wd_q, wd_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    scan_idx;
  logic [ID_W-1:0]    ptr_next;
  logic               terr_set;

  // First requesting source at or above the RR pointer, wrapping modulo NUM_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!pick_found && bus.i_req[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  assign ptr_next = ID_W'((32'(grant_id_q) + 32'd1) % NUM_REQ);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    cmd_d      = 1'b0;
    done_d     = '0;
    err_d      = '0;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    terr_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = OneHot0 << pick_id;
          grant_id_d = pick_id;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        cmd_d   = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done pulse on the expiry cycle still counts as a normal completion
        if (bus.i_image_done_pulse) begin
          done_d  = grant_q;
          cnt_d   = cnt_q + CNT_W'(1);
          ptr_d   = ptr_next;
          state_d = StRelease;
        end else if (wd_q == WdMax) begin
          err_d    = grant_q;
          terr_set = 1'b1;
          ptr_d    = ptr_next;
          state_d  = StRelease;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StRelease: begin
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    terr_d = terr_set | (terr_q & ~bus.i_err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      cmd_q      <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      cmd_q      <= cmd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.o_grant         = grant_q;
  assign bus.o_grant_id      = grant_id_q;
  assign bus.o_img_cmd_pulse = cmd_q;
  assign bus.o_req_done      = done_q;
  assign bus.o_req_err       = err_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_timeout_err   = terr_q;
  assign bus.o_xfer_count    = cnt_q;

endmodule

// File: tb/tb_image_stream_sched.sv
// Self-checking bench for image_stream_sched: expected grants/outcomes are queued at
// stimulus time and retired against the done/err pulses.
module tb_image_stream_sched;

  localparam int NR = 4;
  localparam int TO = 16;

  logic clk;
  logic rst;

  image_stream_sched_if #(.NUM_REQ(NR), .ID_W(2), .CNT_W(16)) bus ();

  image_stream_sched #(
    .NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(TO), .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit err;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = '0;
  bit          m_terr = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(logic [3:0] r, int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // Entered in an IDLE cycle with i_req already driven; leaves in the following IDLE cycle.
  // done_after: WAIT cycles before the done pulse, -1 for a timeout.
  task automatic xfer(input int done_after, input bit spurious, input int clr_at,
                      output int got_id);
    exp_t        e;
    exp_t        o;
    logic [3:0]  oh;
    int          n;
    bit          seen;
    e.id  = model_pick(bus.i_req, m_ptr);
    e.err = (done_after < 0);
    sb.push_back(e);
    oh = 4'(1 << e.id);
    bus.i_image_done_pulse = spurious;
    tick;  // GRANT
    got_id = int'(bus.o_grant_id);
    checks++;
    if (bus.o_grant !== oh || bus.o_grant_id !== 2'(e.id) || bus.o_busy !== 1'b1 ||
        bus.o_img_cmd_pulse !== 1'b0) begin
      errors++;
      $display("FAIL grant: grant=%b id=%0d busy=%b cmd=%b, required grant=%b id=%0d busy=1 cmd=0",
               bus.o_grant, bus.o_grant_id, bus.o_busy, bus.o_img_cmd_pulse, oh, e.id);
    end
    tick;  // ISSUE
    checks++;
    if (bus.o_img_cmd_pulse !== 1'b1) begin
      errors++;
      $display("FAIL cmd_pulse: cmd=%b, required 1", bus.o_img_cmd_pulse);
    end
    bus.i_image_done_pulse = 1'b0;
    tick;  // first WAIT cycle
    checks++;
    if (bus.o_img_cmd_pulse !== 1'b0 || bus.o_req_done !== 4'b0 || bus.o_req_err !== 4'b0) begin
      errors++;
      $display("FAIL cmd_width: cmd=%b done=%b err=%b, required 0/0000/0000",
               bus.o_img_cmd_pulse, bus.o_req_done, bus.o_req_err);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      bus.i_image_done_pulse = (done_after >= 0 && n == done_after);
      bus.i_err_clr = (clr_at >= 0 && n == clr_at);
      tick;
      n++;
      bus.i_image_done_pulse = 1'b0;
      bus.i_err_clr = 1'b0;
      seen = ((bus.o_req_done | bus.o_req_err) != 4'b0);
    end
    o = sb.pop_front();
    if (o.err) m_terr = 1'b1;
    else begin
      m_cnt++;
      if (clr_at >= 0) m_terr = 1'b0;
    end
    m_ptr = (o.id + 1) % NR;
    checks++;
    if (!seen || n != (o.err ? TO : done_after + 1)) begin
      errors++;
      $display("FAIL pulse_latency: seen=%b after %0d cycles, required %0d", seen, n,
               o.err ? TO : done_after + 1);
    end
    checks++;
    if (bus.o_req_done !== (o.err ? 4'b0 : oh) || bus.o_req_err !== (o.err ? oh : 4'b0)) begin
      errors++;
      $display("FAIL outcome: done=%b err=%b, required done=%b err=%b", bus.o_req_done,
               bus.o_req_err, o.err ? 4'b0 : oh, o.err ? oh : 4'b0);
    end
    checks++;
    if (bus.o_xfer_count !== m_cnt || bus.o_timeout_err !== m_terr || bus.o_grant !== oh) begin
      errors++;
      $display("FAIL status: count=%0d terr=%b grant=%b, required count=%0d terr=%b grant=%b",
               bus.o_xfer_count, bus.o_timeout_err, bus.o_grant, m_cnt, m_terr, oh);
    end
    bus.i_req[o.id] = 1'b0;  // source drops its request after completion
    tick;  // IDLE
    checks++;
    if (bus.o_grant !== 4'b0 || bus.o_grant_id !== 2'd0 || bus.o_busy !== 1'b0 ||
        bus.o_req_done !== 4'b0 || bus.o_req_err !== 4'b0) begin
      errors++;
      $display("FAIL release: grant=%b id=%0d busy=%b done=%b err=%b, required all 0",
               bus.o_grant, bus.o_grant_id, bus.o_busy, bus.o_req_done, bus.o_req_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.o_grant !== 4'b0 || bus.o_grant_id !== 2'd0 || bus.o_img_cmd_pulse !== 1'b0 ||
        bus.o_req_done !== 4'b0 || bus.o_req_err !== 4'b0 || bus.o_busy !== 1'b0 ||
        bus.o_timeout_err !== 1'b0 || bus.o_xfer_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: grant=%b id=%0d cmd=%b busy=%b terr=%b count=%0d, required all 0",
               bus.o_grant, bus.o_grant_id, bus.o_img_cmd_pulse, bus.o_busy,
               bus.o_timeout_err, bus.o_xfer_count);
    end
    rst = 1'b0;
    m_ptr  = 0;
    m_cnt  = '0;
    m_terr = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    int id;
    for (int pass = 0; pass < 2; pass++) begin
      bus.i_req = 4'b1111;
      for (int k = 0; k < NR; k++) begin
        xfer(2 + k, 1'b0, -1, id);
        checks++;
        if (id !== k) begin
          errors++;
          $display("FAIL rr_order: pass %0d slot %0d granted %0d, required %0d", pass, k, id, k);
        end
      end
    end
    checks++;
    if (bus.o_xfer_count !== 16'd8) begin
      errors++;
      $display("FAIL rr_count: count=%0d, required 8", bus.o_xfer_count);
    end
  endtask

  task automatic test_single;
    int id;
    bus.i_req = 4'b0010;
    xfer(9, 1'b0, -1, id);
    checks++;
    if (id !== 1) begin
      errors++;
      $display("FAIL single_id: granted %0d, required 1", id);
    end
  endtask

  task automatic test_wrap;
    int id;
    bus.i_req = 4'b1000;
    xfer(1, 1'b0, -1, id);
    bus.i_req = 4'b1001;
    xfer(3, 1'b0, -1, id);
    checks++;
    if (id !== 0) begin
      errors++;
      $display("FAIL wrap_first: granted %0d, required 0", id);
    end
    xfer(0, 1'b0, -1, id);
    checks++;
    if (id !== 3) begin
      errors++;
      $display("FAIL wrap_second: granted %0d, required 3", id);
    end
  endtask

  task automatic test_spurious_done;
    int id;
    bus.i_req = 4'b0000;
    bus.i_image_done_pulse = 1'b1;
    repeat (3) tick;
    bus.i_image_done_pulse = 1'b0;
    tick;
    checks++;
    if (bus.o_xfer_count !== m_cnt || bus.o_busy !== 1'b0 || bus.o_req_done !== 4'b0 ||
        bus.o_req_err !== 4'b0) begin
      errors++;
      $display("FAIL idle_done: count=%0d busy=%b done=%b err=%b, required count=%0d 0 0 0",
               bus.o_xfer_count, bus.o_busy, bus.o_req_done, bus.o_req_err, m_cnt);
    end
    bus.i_req = 4'b0100;
    xfer(5, 1'b1, -1, id);
  endtask

  task automatic test_timeout;
    int id;
    bus.i_req = 4'b0100;
    xfer(-1, 1'b0, -1, id);
    repeat (3) tick;
    checks++;
    if (bus.o_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL terr_sticky: terr=%b, required 1", bus.o_timeout_err);
    end
    bus.i_err_clr = 1'b1;
    tick;
    bus.i_err_clr = 1'b0;
    m_terr = 1'b0;
    checks++;
    if (bus.o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL terr_clear: terr=%b, required 0", bus.o_timeout_err);
    end
    // Clear lands on the expiry cycle: the set must win
    bus.i_req = 4'b0001;
    xfer(-1, 1'b0, TO - 1, id);
  endtask

  task automatic test_reset_mid_wait;
    int id;
    bus.i_req = 4'b0100;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.o_grant !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_xfer_count !== 16'd0 ||
        bus.o_req_done !== 4'b0 || bus.o_req_err !== 4'b0 || bus.o_img_cmd_pulse !== 1'b0 ||
        bus.o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: grant=%b busy=%b count=%0d done=%b err=%b terr=%b, required 0",
               bus.o_grant, bus.o_busy, bus.o_xfer_count, bus.o_req_done, bus.o_req_err,
               bus.o_timeout_err);
    end
    m_ptr  = 0;
    m_cnt  = '0;
    m_terr = 1'b0;
    bus.i_req = 4'b1111;
    xfer(4, 1'b0, -1, id);
    checks++;
    if (id !== 0) begin
      errors++;
      $display("FAIL post_reset_id: granted %0d, required 0", id);
    end
    bus.i_req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.i_req = 4'b0;
    bus.i_image_done_pulse = 1'b0;
    bus.i_err_clr = 1'b0;
    test_reset;
    test_round_robin;
    test_single;
    test_wrap;
    test_spurious_done;
    test_timeout;
    test_reset_mid_wait;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
